pipeline_control: RTL and testbench
===================================

# pipeline_control

Pipeline bookkeeping and hazard controller for the five-stage RISC-V core (IF/ID/EX/MEM/WB). It tracks per-stage metadata (valid, rd, write enable, load flag) behind decode and drives stall, flush, operand-forwarding selects and a qualified register-file write enable. Three saturating performance counters are included. It replaces the hardwired `reg_write_en = 1` and unconditional single-cycle flow of the current datapath. `FORWARD_EN` selects between full forwarding and stall-only interlocking.

## Interface
- `REG_ADDR_WIDTH`, 5, register index width
- `CNT_WIDTH`, 32, performance counter width
- `FORWARD_EN`, 1, 1 = EX/MEM and MEM/WB forwarding with load-use stall; 0 = no forwarding, stall on every RAW hazard
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `id_valid`  in  1  decode holds a real instruction
- `id_rs1`, `id_rs2`  in  REG_ADDR_WIDTH  decode source registers
- `id_uses_rs1`, `id_uses_rs2`  in  1  source actually read
- `id_rd`  in  REG_ADDR_WIDTH  decode destination
- `id_reg_write`, `id_mem_read`  in  1  decode writes rd / is a load
- `ex_branch_taken`  in  1  branch/JAL resolved taken in EX
- `stall_if`  out  1  hold PC and IF/ID register
- `flush_id`, `flush_ex`  out  1  squash IF/ID contents / insert bubble into ID/EX
- `fwd_a`, `fwd_b`  out  2  EX operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
- `wb_reg_write`  out  1  qualified regfile write enable
- `wb_rd`  out  REG_ADDR_WIDTH  regfile write address
- `cnt_retired`, `cnt_stall`, `cnt_flush`  out  CNT_WIDTH  performance counters

## Operation
- Three metadata slots: EX {valid, rd, reg_write, mem_read, rs1, rs2, uses_rs1, uses_rs2}, MEM {valid, rd, reg_write, mem_read}, WB {valid, rd, reg_write}.
- Each cycle: WB <= MEM; MEM <= EX; EX <= decode fields with valid = `id_valid & ~stall & ~flush`.
- A slot "writes r" when valid & reg_write & rd == r & r != 0. x0 never hazards and is never forwarded.
- FORWARD_EN=1: stall = `id_valid` & EX.mem_read & EX writes a used source (load-use).
- FORWARD_EN=0: stall = `id_valid` & any of EX/MEM/WB writes a used source. `fwd_a`/`fwd_b` are held at 00.
- Forward select (FORWARD_EN=1), computed from the EX slot: 01 if MEM writes EX.rs1 and EX.uses_rs1; else 10 if WB writes it; else 00. MEM takes priority. The same rule applies to `fwd_b` with rs2. Unused sources give 00.
- Taken branch: `taken = ex_branch_taken & EX.valid`. It asserts `flush_id` and `flush_ex`. The EX slot loads a bubble and decode contents are discarded.
- Stall and taken in the same cycle: flush wins. `stall_if` = 0 and `cnt_stall` does not increment.
- `stall_if` = stall & ~taken.
- `wb_reg_write` = WB.valid & WB.reg_write & WB.rd != 0. `wb_rd` = WB.rd.
- Counters:
  - `cnt_retired` increments when WB.valid.
  - `cnt_stall` increments on each `stall_if` cycle.
  - `cnt_flush` increments on each taken cycle.
  - All counters saturate at all-ones and never wrap.

## Timing
- Reset (async assert, sync-safe deassert): all slot valids 0, slot fields 0, counters 0. Outputs are therefore `stall_if` 0, flush 0, fwd 00, `wb_reg_write` 0, `wb_rd` 0.
- `stall_if`, `flush_*`, `fwd_*`, `wb_*` are combinational from registered slots plus current `id_*` and `ex_branch_taken`. No input-to-state combinational loops.
- Issue to writeback: an instruction accepted from ID at edge N is in WB during cycle N+2. Retirement is counted at edge N+3.
- Load-use costs exactly 1 bubble with FORWARD_EN=1. With FORWARD_EN=0, a RAW on the previous instruction costs 3 bubbles.
- Taken branch costs 2 squashed slots: decode plus the EX bubble.
- Reset mid-operation drops all in-flight metadata immediately. No writeback occurs after reset asserts.

## Structure
- Package `pipe_pkg`: `FWD_REG=2'b00`, `FWD_MEM=2'b01`, `FWD_WB=2'b10`; packed slot typedefs `ex_slot_t`, `mem_slot_t`, `wb_slot_t`.
- Sub-module `sat_counter` (parameter WIDTH; inputs clk, reset, inc; output count), instantiated three times.

## Test plan
- Back-to-back ALU RAW (`add x5,..` then `sub x6,x5,x1`), FORWARD_EN=1 -> `fwd_a`=01 in the sub's EX cycle, no stall; a third instruction reading x5 gets `fwd_a`=10.
- `lw x7` then `add x8,x7,x7` -> `stall_if`=1 for exactly 1 cycle and `cnt_stall`=1; afterwards `fwd_a`=`fwd_b`=10.
- Same RAW pair with FORWARD_EN=0 -> 3 stall cycles, fwd stays 00, `cnt_stall`=3.
- `ex_branch_taken`=1 while a load-use stall is pending -> `flush_id`=`flush_ex`=1, `stall_if`=0, `cnt_flush`=1, and the squashed instructions never raise `wb_reg_write`.
- Writes to x0 -> never forwarded or stalled, and `wb_reg_write`=0; a CNT_WIDTH=4 run of 20 instructions -> `cnt_retired` holds at 15.
- Reset pulled low with 3 valid slots in flight -> all outputs 0 asynchronously; after release, `cnt_retired` stays 0 until a newly issued instruction retires.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the five-stage core's pipeline controller.
//   FWD_*        : EX operand-select encodings driven on fwd_a / fwd_b
//   ex_slot_t    : metadata of the instruction sitting in EX
//   mem_slot_t   : metadata of the instruction sitting in MEM
//   wb_slot_t    : metadata of the instruction sitting in WB
//   slot_writes  : "this slot will write register r" (x0 never counts)
//   fwd_sel      : operand-select for one EX source given the MEM/WB slots
package pipe_pkg;

  // Slot register fields are sized here; the controller's REG_ADDR_WIDTH
  // defaults to this value and the decode indices are cast onto it.
  localparam int SLOT_AW = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rd;
    logic               reg_write;
    logic               mem_read;
    logic [SLOT_AW-1:0] rs1;
    logic [SLOT_AW-1:0] rs2;
    logic               uses_rs1;
    logic               uses_rs2;
  } ex_slot_t;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rd;
    logic               reg_write;
    logic               mem_read;
  } mem_slot_t;

  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] rd;
    logic               reg_write;
  } wb_slot_t;

  function automatic logic slot_writes(input logic valid, input logic reg_write,
                                       input logic [SLOT_AW-1:0] rd,
                                       input logic [SLOT_AW-1:0] r);
    return valid & reg_write & (rd == r) & (r != '0);
  endfunction

  // MEM is the younger producer, so it wins over WB.
  function automatic logic [1:0] fwd_sel(input logic uses, input logic [SLOT_AW-1:0] r,
                                         input mem_slot_t m, input wb_slot_t w);
    if (uses & slot_writes(m.valid, m.reg_write, m.rd, r)) return FWD_MEM;
    if (uses & slot_writes(w.valid, w.reg_write, w.rd, r)) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset, clears count
//   inc   : count this cycle
//   count : current value
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 count <= '0;
    else if (inc && (~&count))  count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_control.sv
// pipeline_control: bookkeeping and hazard control for the IF/ID/EX/MEM/WB core.
//   clk, reset               : clock; asynchronous active-low reset
//   id_*                     : decode-stage instruction fields
//   ex_branch_taken          : branch/JAL in EX resolved taken
//   stall_if                 : hold PC and IF/ID
//   flush_id / flush_ex      : squash IF/ID / insert bubble into ID/EX
//   fwd_a / fwd_b            : EX operand select (regfile / EX-MEM / MEM-WB)
//   wb_reg_write / wb_rd     : qualified regfile write port
//   cnt_retired/stall/flush  : saturating performance counters
// FORWARD_EN=1 forwards from MEM and WB and only interlocks on load-use;
// FORWARD_EN=0 interlocks on any RAW against EX, MEM or WB.
module pipeline_control import pipe_pkg::*; #(
  parameter int REG_ADDR_WIDTH = SLOT_AW,
  parameter int CNT_WIDTH      = 32,
  parameter int FORWARD_EN     = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      ex_branch_taken,
  output logic                      stall_if,
  output logic                      flush_id,
  output logic                      flush_ex,
  output logic [1:0]                fwd_a,
  output logic [1:0]                fwd_b,
  output logic                      wb_reg_write,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic [CNT_WIDTH-1:0]      cnt_retired,
  output logic [CNT_WIDTH-1:0]      cnt_stall,
  output logic [CNT_WIDTH-1:0]      cnt_flush
);

  ex_slot_t  ex_q, ex_d;
  mem_slot_t mem_q;
  wb_slot_t  wb_q;

  logic [SLOT_AW-1:0] rs1, rs2;
  logic stall, taken, hit_ex;

  assign rs1 = SLOT_AW'(id_rs1);
  assign rs2 = SLOT_AW'(id_rs2);

  // Does the decode instruction read a register the EX slot will write?
  assign hit_ex = (id_uses_rs1 & slot_writes(ex_q.valid, ex_q.reg_write, ex_q.rd, rs1)) |
                  (id_uses_rs2 & slot_writes(ex_q.valid, ex_q.reg_write, ex_q.rd, rs2));

  generate
    if (FORWARD_EN != 0) begin : g_fwd
      // Only a load in EX cannot be bypassed in time for the next EX.
      assign stall = id_valid & ex_q.mem_read & hit_ex;
      assign fwd_a = fwd_sel(ex_q.uses_rs1, ex_q.rs1, mem_q, wb_q);
      assign fwd_b = fwd_sel(ex_q.uses_rs2, ex_q.rs2, mem_q, wb_q);
    end else begin : g_nofwd
      logic hit_mem, hit_wb, unused_ex_src;
      assign hit_mem = (id_uses_rs1 & slot_writes(mem_q.valid, mem_q.reg_write, mem_q.rd, rs1)) |
                       (id_uses_rs2 & slot_writes(mem_q.valid, mem_q.reg_write, mem_q.rd, rs2));
      assign hit_wb  = (id_uses_rs1 & slot_writes(wb_q.valid, wb_q.reg_write, wb_q.rd, rs1)) |
                       (id_uses_rs2 & slot_writes(wb_q.valid, wb_q.reg_write, wb_q.rd, rs2));
      // WB is still in flight: the regfile is written at the end of that cycle.
      assign stall = id_valid & (hit_ex | hit_mem | hit_wb);
      assign fwd_a = FWD_REG;
      assign fwd_b = FWD_REG;
      assign unused_ex_src = ^{ex_q.rs1, ex_q.rs2, ex_q.uses_rs1, ex_q.uses_rs2};
    end
  endgenerate

  assign taken    = ex_branch_taken & ex_q.valid;
  assign stall_if = stall & ~taken;   // a flush discards decode, so nothing to hold
  assign flush_id = taken;
  assign flush_ex = taken;

  // Bubbles are loaded as all-zero so a dead EX slot never selects a bypass.
  always_comb begin
    ex_d = '0;
    if (id_valid & ~stall & ~taken) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = SLOT_AW'(id_rd);
      ex_d.reg_write = id_reg_write;
      ex_d.mem_read  = id_mem_read;
      ex_d.rs1       = rs1;
      ex_d.rs2       = rs2;
      ex_d.uses_rs1  = id_uses_rs1;
      ex_d.uses_rs2  = id_uses_rs2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write,
                 mem_read: ex_q.mem_read};
      wb_q  <= '{valid: mem_q.valid, rd: mem_q.rd, reg_write: mem_q.reg_write};
    end
  end

  // The MEM load flag is kept for the memory stage's own use, not here.
  logic unused_mem_read;
  assign unused_mem_read = mem_q.mem_read;

  assign wb_reg_write = wb_q.valid & wb_q.reg_write & (wb_q.rd != '0);
  assign wb_rd        = REG_ADDR_WIDTH'(wb_q.rd);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_retired (
    .clk(clk), .reset(reset), .inc(wb_q.valid), .count(cnt_retired));
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_stall (
    .clk(clk), .reset(reset), .inc(stall_if), .count(cnt_stall));
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_flush (
    .clk(clk), .reset(reset), .inc(taken), .count(cnt_flush));

endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: three controllers (forwarding, interlock-only, forwarding
// with 4-bit counters) share one stimulus stream. A reference model keeps the
// history of which instruction entered EX on each edge and derives hazards,
// selects, writebacks and counters from that history.
module tb_pipeline_control;

  localparam int NC = 3;

  typedef struct {
    bit       v;
    bit [4:0] rd, rs1, rs2;
    bit       rw, mr, u1, u2;
  } ins_t;

  logic clk = 1'b0;
  logic reset;
  logic id_valid = 0, id_uses_rs1 = 0, id_uses_rs2 = 0, id_reg_write = 0, id_mem_read = 0;
  logic ex_branch_taken = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;

  logic        stall_if [NC], flush_id [NC], flush_ex [NC], wb_reg_write [NC];
  logic [1:0]  fwd_a [NC], fwd_b [NC];
  logic [4:0]  wb_rd [NC];
  logic [31:0] cnt_r [NC], cnt_s [NC], cnt_f [NC];
  logic [3:0]  sr, ss, sf;
  assign cnt_r[2] = {28'd0, sr};
  assign cnt_s[2] = {28'd0, ss};
  assign cnt_f[2] = {28'd0, sf};

  always #5 clk = ~clk;

  pipeline_control #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32), .FORWARD_EN(1)) u_fwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
    .stall_if(stall_if[0]), .flush_id(flush_id[0]), .flush_ex(flush_ex[0]),
    .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .wb_reg_write(wb_reg_write[0]), .wb_rd(wb_rd[0]),
    .cnt_retired(cnt_r[0]), .cnt_stall(cnt_s[0]), .cnt_flush(cnt_f[0]));

  pipeline_control #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32), .FORWARD_EN(0)) u_nofwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
    .stall_if(stall_if[1]), .flush_id(flush_id[1]), .flush_ex(flush_ex[1]),
    .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .wb_reg_write(wb_reg_write[1]), .wb_rd(wb_rd[1]),
    .cnt_retired(cnt_r[1]), .cnt_stall(cnt_s[1]), .cnt_flush(cnt_f[1]));

  pipeline_control #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4), .FORWARD_EN(1)) u_small (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_branch_taken(ex_branch_taken),
    .stall_if(stall_if[2]), .flush_id(flush_id[2]), .flush_ex(flush_ex[2]),
    .fwd_a(fwd_a[2]), .fwd_b(fwd_b[2]), .wb_reg_write(wb_reg_write[2]), .wb_rd(wb_rd[2]),
    .cnt_retired(sr), .cnt_stall(ss), .cnt_flush(sf));

  // ---------------- reference model ----------------
  ins_t   hist [NC][0:2047];   // hist[c][e] = instruction that entered EX at edge e
  int     cyc;                 // edges since reset release
  longint er [NC], es [NC], ef [NC];
  int     vectors = 0, miscompares = 0;

  logic       obs_stall [NC], obs_fi [NC], obs_fe [NC], obs_wbw [NC];
  logic [1:0] obs_fa [NC], obs_fb [NC];
  logic [4:0] obs_wbrd [NC];

  function automatic bit fe(int c); return c != 1; endfunction
  function automatic longint cmax(int c); return (c == 2) ? 64'd15 : 64'hFFFF_FFFF; endfunction

  function automatic ins_t slot(int c, int d);   // d: 0 = EX, 1 = MEM, 2 = WB
    ins_t z;
    z = '{default:0};
    if (cyc - d < 0) return z;
    return hist[c][cyc-d];
  endfunction

  function automatic bit wr(ins_t i, bit [4:0] r);
    return i.v && i.rw && (i.rd == r) && (r != 0);
  endfunction

  function automatic bit reads(ins_t d, ins_t p);
    return (d.u1 && wr(p, d.rs1)) || (d.u2 && wr(p, d.rs2));
  endfunction

  function automatic bit [1:0] fsel(bit u, bit [4:0] r, ins_t m, ins_t w);
    if (u && wr(m, r)) return 2'b01;
    if (u && wr(w, r)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic ins_t mk(int rd, int rw, int mr, int rs1, int u1, int rs2, int u2);
    ins_t i;
    i.v = 1'b1; i.rd = 5'(rd); i.rw = 1'(rw); i.mr = 1'(mr);
    i.rs1 = 5'(rs1); i.u1 = 1'(u1); i.rs2 = 5'(rs2); i.u2 = 1'(u2);
    return i;
  endfunction

  task automatic chk(input string tag, input int c, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s [cfg%0d]: observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  // One cycle: drive decode at negedge, check combinational and counter
  // outputs, then advance the model across the rising edge.
  task automatic step(input ins_t d, input bit br);
    ins_t nx [NC];
    @(negedge clk);
    id_valid = d.v; id_rd = d.rd; id_rs1 = d.rs1; id_rs2 = d.rs2;
    id_reg_write = d.rw; id_mem_read = d.mr; id_uses_rs1 = d.u1; id_uses_rs2 = d.u2;
    ex_branch_taken = br;
    #1;
    for (int c = 0; c < NC; c++) begin
      ins_t ex, mm, wb;
      bit haz, tk, st;
      ex = slot(c, 0); mm = slot(c, 1); wb = slot(c, 2);
      if (fe(c)) haz = ex.mr && reads(d, ex);
      else       haz = reads(d, ex) || reads(d, mm) || reads(d, wb);
      haz = haz && d.v;
      tk  = br && ex.v;
      st  = haz && !tk;
      obs_stall[c] = stall_if[c]; obs_fi[c] = flush_id[c]; obs_fe[c] = flush_ex[c];
      obs_fa[c] = fwd_a[c]; obs_fb[c] = fwd_b[c];
      obs_wbw[c] = wb_reg_write[c]; obs_wbrd[c] = wb_rd[c];
      chk("stall_if", c, stall_if[c], st);
      chk("flush_id", c, flush_id[c], tk);
      chk("flush_ex", c, flush_ex[c], tk);
      if (!fe(c)) begin
        chk("fwd_a_off", c, fwd_a[c], 2'b00);
        chk("fwd_b_off", c, fwd_b[c], 2'b00);
      end else if (ex.v) begin
        chk("fwd_a", c, fwd_a[c], fsel(ex.u1, ex.rs1, mm, wb));
        chk("fwd_b", c, fwd_b[c], fsel(ex.u2, ex.rs2, mm, wb));
      end
      chk("wb_reg_write", c, wb_reg_write[c], wr(wb, wb.rd));
      if (wb.v) chk("wb_rd", c, wb_rd[c], wb.rd);
      chk("cnt_retired", c, cnt_r[c], er[c]);
      chk("cnt_stall", c, cnt_s[c], es[c]);
      chk("cnt_flush", c, cnt_f[c], ef[c]);
      nx[c] = d;
      nx[c].v = d.v && !haz && !tk;
      if (wb.v && er[c] < cmax(c)) er[c]++;
      if (st   && es[c] < cmax(c)) es[c]++;
      if (tk   && ef[c] < cmax(c)) ef[c]++;
    end
    @(posedge clk);
    cyc++;
    for (int c = 0; c < NC; c++) hist[c][cyc] = nx[c];
    #1;
  endtask

  // Reset asserted mid-cycle: everything must drop before the next edge.
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    for (int c = 0; c < NC; c++) begin
      chk("rst_stall", c, stall_if[c], 0);
      chk("rst_flush_id", c, flush_id[c], 0);
      chk("rst_flush_ex", c, flush_ex[c], 0);
      chk("rst_fwd_a", c, fwd_a[c], 0);
      chk("rst_fwd_b", c, fwd_b[c], 0);
      chk("rst_wb_we", c, wb_reg_write[c], 0);
      chk("rst_wb_rd", c, wb_rd[c], 0);
      chk("rst_cnt_r", c, cnt_r[c], 0);
      chk("rst_cnt_s", c, cnt_s[c], 0);
      chk("rst_cnt_f", c, cnt_f[c], 0);
      er[c] = 0; es[c] = 0; ef[c] = 0;
      for (int i = 0; i < 2048; i++) hist[c][i] = '{default:0};
    end
    cyc = 0;
    id_valid = 1'b0; ex_branch_taken = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    ins_t nop, r;
    nop = '{default:0};
    reset = 1'b1;
    #1 reset = 1'b0;
    do_reset();

    // ALU RAW chain with forwarding: add x5 ; sub x6,x5,x1 ; or x9,x5
    step(mk(5,1,0, 1,1, 2,1), 0);
    step(mk(6,1,0, 5,1, 1,1), 0); chk("raw_nostall", 0, obs_stall[0], 0);
    step(mk(9,1,0, 5,1, 0,0), 0); chk("raw_fwd_mem", 0, obs_fa[0], 2'b01);
    step(nop, 0);                 chk("raw_fwd_wb", 0, obs_fa[0], 2'b10);

    // load-use: lw x7 ; add x8,x7,x7
    do_reset();
    step(mk(7,1,1, 1,1, 0,0), 0);
    step(mk(8,1,0, 7,1, 7,1), 0); chk("lu_stall", 0, obs_stall[0], 1);
    step(mk(8,1,0, 7,1, 7,1), 0); chk("lu_release", 0, obs_stall[0], 0);
    step(nop, 0);
    chk("lu_fwd_a", 0, obs_fa[0], 2'b10);
    chk("lu_fwd_b", 0, obs_fb[0], 2'b10);
    chk("lu_cnt_stall", 0, cnt_s[0], 1);

    // interlock-only: the dependent sub waits 3 cycles
    do_reset();
    step(mk(5,1,0, 1,1, 2,1), 0);
    for (int k = 0; k < 3; k++) begin
      step(mk(6,1,0, 5,1, 1,1), 0);
      chk("nf_stall", 1, obs_stall[1], 1);
      chk("nf_fwd_a", 1, obs_fa[1], 2'b00);
    end
    step(mk(6,1,0, 5,1, 1,1), 0); chk("nf_accept", 1, obs_stall[1], 0);
    chk("nf_cnt_stall", 1, cnt_s[1], 3);

    // taken branch while a load-use stall is pending
    do_reset();
    step(mk(7,1,1, 1,1, 0,0), 0);
    step(mk(8,1,0, 7,1, 7,1), 1);
    chk("br_flush_id", 0, obs_fi[0], 1);
    chk("br_flush_ex", 0, obs_fe[0], 1);
    chk("br_stall", 0, obs_stall[0], 0);
    for (int k = 0; k < 4; k++) begin
      step(nop, 0);
      chk("br_squashed_wb", 0, obs_wbw[0] && (obs_wbrd[0] == 5'd8), 0);
    end
    chk("br_cnt_flush", 0, cnt_f[0], 1);
    chk("br_cnt_stall", 0, cnt_s[0], 0);

    // x0 destination: no hazard, no bypass, no write
    do_reset();
    step(mk(0,1,1, 1,1, 0,0), 0);
    step(mk(3,1,0, 0,1, 0,1), 0);
    chk("x0_nostall_fwd", 0, obs_stall[0], 0);
    chk("x0_nostall_nofwd", 1, obs_stall[1], 0);
    step(nop, 0); chk("x0_fwd_a", 0, obs_fa[0], 0); chk("x0_fwd_b", 0, obs_fb[0], 0);
    step(nop, 0); chk("x0_wb_we", 0, obs_wbw[0], 0);

    // 20 independent instructions: 4-bit counter saturates at 15
    do_reset();
    for (int k = 0; k < 20; k++) step(mk(10 + k % 5, 1,0, 0,0, 0,0), 0);
    for (int k = 0; k < 3; k++) step(nop, 0);
    chk("sat_retired4", 2, cnt_r[2], 15);
    chk("retired32", 0, cnt_r[0], 20);

    // reset with EX/MEM/WB all occupied, then a fresh retirement
    do_reset();
    step(mk(11,1,0, 0,0, 0,0), 0);
    step(mk(12,1,0, 0,0, 0,0), 0);
    step(mk(13,1,0, 0,0, 0,0), 0);
    do_reset();
    for (int k = 0; k < 3; k++) step(nop, 0);
    chk("post_rst_idle", 0, cnt_r[0], 0);
    step(mk(14,1,0, 0,0, 0,0), 0);
    step(nop, 0); step(nop, 0);
    chk("post_rst_pending", 0, cnt_r[0], 0);
    step(nop, 0);
    chk("post_rst_retire", 0, cnt_r[0], 1);

    // random traffic over a small register set to provoke hazards
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r.v   = ($urandom_range(0, 9) != 0);
      r.rd  = 5'($urandom_range(0, 7));
      r.rs1 = 5'($urandom_range(0, 7));
      r.rs2 = 5'($urandom_range(0, 7));
      r.rw  = ($urandom_range(0, 4) != 0);
      r.mr  = ($urandom_range(0, 2) == 0);
      r.u1  = 1'($urandom_range(0, 1));
      r.u2  = 1'($urandom_range(0, 1));
      step(r, ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
